// File: rtl/mac_rr_scheduler.sv
// Round-robin scheduler that shares one fixed-latency pipelined MAC among NREQ requesters.
// Define MAC_RR_SCHEDULER_STATS_EN to add per-requester saturating grant counters.
module mac_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int LAT  = 3,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_m1,
    input  logic [NREQ*W-1:0] req_m2,
    input  logic [NREQ*W-1:0] req_addend,
    output logic [NREQ-1:0]   req_ready,
    output logic              mac_issue,
    output logic [W-1:0]      mac_m1,
    output logic [W-1:0]      mac_m2,
    output logic [W-1:0]      mac_addend,
    input  logic [2*W-1:0]    mac_result,
    output logic              resp_valid,
    output logic [IDW-1:0]    resp_id,
    output logic [2*W-1:0]    resp_data,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              busy
`ifdef MAC_RR_SCHEDULER_STATS_EN
    ,
    input  logic [IDW-1:0]    stat_sel,
    input  logic              stat_clr,
    output logic [15:0]       stat_count
`endif
);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);
    localparam logic [IDW:0]   NREQ_W  = (IDW + 1)'(NREQ);

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gnt_id;
    logic [IDW:0]    gnt_sum;
    logic            gnt_any;
    logic            arb_en;
    logic            xfer;
    logic [NREQ-1:0] rot;
    logic [NREQ-1:0] grant;
    logic [W-1:0]    sel_m1;
    logic [W-1:0]    sel_m2;
    logic [W-1:0]    sel_add;
    logic [IDW-1:0]  id_p0;
    logic [LAT-1:0]  vld_p1;
    logic [IDW-1:0]  id_p1 [LAT];

    // Flush is honoured in the very cycle it is first seen, so no grant slips through.
    assign arb_en = RST && (state == S_RUN) && !flush_req;
    assign rot    = NREQ'({req_valid, req_valid} >> ptr);

    always_comb begin
        gnt_any = 1'b0;
        gnt_sum = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_any = 1'b1;
                gnt_sum = {1'b0, ptr} + (IDW + 1)'(k);
            end
        end
        if (gnt_sum >= NREQ_W)
            gnt_sum = gnt_sum - NREQ_W;
        gnt_id = gnt_sum[IDW-1:0];
    end

    assign xfer      = arb_en && gnt_any;
    assign grant     = xfer ? ({{(NREQ - 1){1'b0}}, 1'b1} << gnt_id) : '0;
    assign req_ready = grant;

    always_comb begin
        sel_m1  = '0;
        sel_m2  = '0;
        sel_add = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_m1  = req_m1[i*W +: W];
                sel_m2  = req_m2[i*W +: W];
                sel_add = req_addend[i*W +: W];
            end
        end
    end

    // p0: issue stage, p1: LAT-deep tag pipeline aligned with the MAC latency
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= S_RUN;
            ptr        <= '0;
            mac_issue  <= 1'b0;
            mac_m1     <= '0;
            mac_m2     <= '0;
            mac_addend <= '0;
            vld_p1     <= '0;
            flush_done <= 1'b0;
        end else begin
            mac_issue <= xfer;
            if (xfer) begin
                mac_m1     <= sel_m1;
                mac_m2     <= sel_m2;
                mac_addend <= sel_add;
                ptr        <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
            end
            vld_p1[0] <= mac_issue;
            for (int k = 1; k < LAT; k++)
                vld_p1[k] <= vld_p1[k-1];
            flush_done <= 1'b0;
            case (state)
                S_RUN:   if (flush_req) state <= S_DRAIN;
                S_DRAIN: if (!busy) begin
                    state      <= S_DONE;
                    flush_done <= 1'b1;
                end
                S_DONE:  if (!flush_req) state <= S_RUN;
                default: state <= S_RUN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (xfer)
            id_p0 <= gnt_id;
        id_p1[0] <= id_p0;
        for (int k = 1; k < LAT; k++)
            id_p1[k] <= id_p1[k-1];
    end

    assign resp_valid = vld_p1[LAT-1];
    assign resp_id    = resp_valid ? id_p1[LAT-1] : '0;
    assign resp_data  = resp_valid ? mac_result : '0;
    assign busy       = mac_issue | (|vld_p1);

`ifdef MAC_RR_SCHEDULER_STATS_EN
    logic [15:0] stat_cnt [NREQ];

    always_ff @(posedge CLK) begin
        for (int i = 0; i < NREQ; i++) begin
            if (!RST || stat_clr)
                stat_cnt[i] <= '0;
            else if (grant[i] && (stat_cnt[i] != 16'hFFFF))
                stat_cnt[i] <= stat_cnt[i] + 16'd1;
        end
    end

    assign stat_count = (32'(stat_sel) < NREQ) ? stat_cnt[stat_sel] : '0;
`endif

endmodule

// File: doc/mac_rr_scheduler.md
Name: mac_rr_scheduler

Overview:
- Shares one pipelined MAC datapath (result = m1*m2 + addend, 64-bit) between NREQ requesters using round-robin arbitration.
- Issues at most one operation per cycle and tracks requester IDs through the fixed-latency MAC pipeline. Returns each result tagged with the issuing requester's ID.
- Provides a flush/drain sequence so software can quiesce the MAC before reconfiguring it.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, operand width; result width is 2*W.
- LAT, 3, cycles from mac_issue to a valid mac_result at the MAC (1..8).

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  per-requester operation valid.
- req_m1  in  NREQ*W  packed multiplicand 1; requester i occupies slice [i*W +: W].
- req_m2  in  NREQ*W  packed multiplicand 2, same packing.
- req_addend  in  NREQ*W  packed addend, same packing.
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- mac_issue  out  1  registered strobe to the MAC.
- mac_m1  out  W  registered operand to the MAC.
- mac_m2  out  W  registered operand to the MAC.
- mac_addend  out  W  registered operand to the MAC.
- mac_result  in  2*W  MAC output; valid exactly LAT cycles after mac_issue.
- resp_valid  out  1  result valid pulse.
- resp_id  out  clog2(NREQ)  ID of the requester that owns resp_data.
- resp_data  out  2*W  result.
- flush_req  in  1  request to stop granting and drain the pipeline.
- flush_done  out  1  one-cycle pulse when the drain completes.
- busy  out  1  high while any operation is in flight or a grant is pending.

Behaviour:
- Reset (RST=0 at a clock edge) clears the following:
  - all outputs to 0; req_ready combinationally 0 while RST=0;
  - round-robin pointer to 0, so requester 0 has highest priority;
  - tag pipeline to all-invalid;
  - FSM to RUN.
- Reset mid-operation discards in-flight tags. No resp_valid is produced for operations already issued.
- FSM states:
  - RUN: arbitration enabled.
  - DRAIN: no grants; waits until the tag pipeline is empty and the issue stage is idle.
  - DONE: asserts flush_done for one cycle, then returns to RUN if flush_req=0, otherwise stays in DONE.
- FSM transitions:
  - RUN to DRAIN when flush_req=1. No grant is made in the cycle flush_req is first sampled high.
  - DRAIN to DONE when nothing is in flight. Entering DRAIN with an empty pipeline still takes 1 cycle in DRAIN.
  - DONE with flush_req held high: flush_done pulses once only.
- Arbitration (RUN only):
  - Search starts at pointer p and proceeds p, p+1, … modulo NREQ; the first i with req_valid[i] is granted.
  - req_ready is combinational from req_valid and p.
  - After a transfer, p becomes (granted+1) mod NREQ. With no transfer, p holds.
- Issue stage:
  - The granted requester's operands are registered onto mac_m1/m2/addend, and mac_issue=1 the cycle after the transfer.
  - mac_issue is 0 otherwise; the operand registers hold their last values.
- Tag pipeline:
  - LAT-deep shift register of {valid, id}, loaded from the issue stage.
  - When a stage-LAT entry is valid, resp_valid=1, resp_id=its id, and resp_data=mac_result in that same cycle.
  - Total latency from transfer to resp_valid is LAT+1 cycles. Throughput is 1 operation per cycle.
- The MAC must process every mac_issue, including identical back-to-back operands, with fixed latency LAT. Responses have no backpressure.
- busy = issue stage valid OR any tag valid.
- Arithmetic: no truncation in this block; resp_data passes the full 2*W bits through.

Optional Feature:
- Macro: MAC_RR_SCHEDULER_STATS_EN.
- When defined, adds:
  - input stat_sel (clog2(NREQ) bits);
  - output stat_count (16 bits): grant counter for requester stat_sel;
  - input stat_clr: synchronous clear of all counters.
- Counter rules:
  - Each counter increments on its requester's transfer and saturates at 16'hFFFF.
  - Counters are cleared by reset and by stat_clr. stat_clr wins over a same-cycle increment.
- When not defined, these ports and counters are absent and the block's behaviour is otherwise identical.

Test Plan:
- Single requester:
  - Stimulus: after reset, req_valid=4'b0001 with m1=3, m2=5, addend=7 for 1 cycle.
  - Required: req_ready=4'b0001, mac_issue at t+1, resp_valid at t+4 with resp_id=0 and resp_data=22.
- All requesters, round robin:
  - Stimulus: req_valid=4'b1111 held for 8 cycles.
  - Required: grant order 0,1,2,3,0,1,2,3 and 8 consecutive resp_valid with matching IDs.
- Pointer after a grant:
  - Stimulus: grant requester 2, then req_valid=4'b0101.
  - Required: next grant is 0, because the search runs 3, 0.
- Flush:
  - Stimulus: flush_req=1 while 3 operations are in flight.
  - Required: no further req_ready; all 3 resp_valid still appear; flush_done pulses once, the cycle after the last tag clears; busy=0 at that point.
- Reset mid-stream:
  - Stimulus: RST=0 for 1 cycle with 2 operations in flight.
  - Required: no resp_valid afterwards; pointer=0; req_ready=0 while RST=0.
- With stats enabled:
  - Stimulus: 5 grants to requester 1, then stat_sel=1.
  - Required: stat_count=5; after stat_clr, stat_count=0.
